// File: rtl/player_pkg.sv
// Shared player definitions: screen and sprite constants plus the vertical motion state type.
// Also imported by the sprite stage.
package player_pkg;

  localparam int PLAYER_WIDTH = 40;
  localparam int SMALL        = 40;
  localparam int BIG          = 80;
  localparam int YRES         = 480;
  localparam int XRES         = 640;

  typedef logic [9:0] xpos_t;
  typedef logic [8:0] ypos_t;

  typedef enum logic [1:0] {
    GROUND  = 2'b00,
    RISING  = 2'b01,
    FALLING = 2'b10
  } vstate_e;

  function automatic logic [10:0] player_height(input logic big);
    return big ? 11'(BIG) : 11'(SMALL);
  endfunction

endpackage

// File: rtl/player_if.sv
// Player control bundle: keyboard/event inputs towards the controller, sprite state back out.
interface player_if;
  import player_pkg::*;

  logic  vsync_in;
  logic  key_left;
  logic  key_right;
  logic  key_jump;
  logic  grow;
  logic  hit;
  logic  flower;
  xpos_t xpos;
  ypos_t ypos;
  logic  direction;
  logic  size;
  logic  fire;
  logic  dead;

  modport master (
    output vsync_in, key_left, key_right, key_jump, grow, hit, flower,
    input  xpos, ypos, direction, size, fire, dead
  );

  modport slave (
    input  vsync_in, key_left, key_right, key_jump, grow, hit, flower,
    output xpos, ypos, direction, size, fire, dead
  );

endinterface

// File: rtl/player_frame_tick.sv
// Vsync rising-edge detector: one-clock frame tick while vsync_in is high and was low last clock.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_d_r;

  // Delayed copy of vsync for the edge compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d_r <= 1'b0;
    end else begin
      vsync_d_r <= vsync_in;
    end
  end

  assign tick = vsync_in & ~vsync_d_r;

endmodule

// File: rtl/player_ctrl.sv
// Player controller: per-frame walk/jump physics and per-clock power-up state.
// Build option: define PLAYER_FIRE_EN to enable the fire-flower power-up.
module player_ctrl
  import player_pkg::*;
#(
  parameter int XSTART     = 20,
  parameter int XMAX       = 600,
  parameter int YMAX       = 400,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_V0    = 12,
  parameter int GRAVITY    = 1,
  parameter int VFALL_MAX  = 10
) (
  input logic     clk,
  input logic     rst,
  player_if.slave bus
);

  localparam logic [10:0] XMAX_11  = 11'(XMAX);
  localparam logic [10:0] YMAX_11  = 11'(YMAX);
  localparam logic [10:0] WALK_11  = 11'(WALK_SPEED);
  localparam logic [10:0] VMAX_11  = 11'(VFALL_MAX);
  localparam logic [4:0]  JUMP_V0_5 = 5'(JUMP_V0);
  localparam logic [4:0]  GRAVITY_5 = 5'(GRAVITY);

  logic        tick_s;
  logic        move_s;

  xpos_t       xpos_r, xpos_s;
  ypos_t       ypos_r, ypos_s;
  logic        dir_r, dir_s;
  logic        size_r, size_s;
  logic        fire_r, fire_s;
  logic        dead_r, dead_s;
  vstate_e     state_r, state_s;
  logic [4:0]  vy_r, vy_s;

  logic [10:0] x_ext_s;
  logic [10:0] y_ext_s;
  logic [10:0] height_s;
  logic [10:0] rise_sum_s;
  logic [10:0] fall_vy_s;

  frame_tick u_frame_tick (
    .clk      (clk),
    .rst      (rst),
    .vsync_in (bus.vsync_in),
    .tick     (tick_s)
  );

  assign move_s = tick_s & ~dead_r;

  // Horizontal walk with saturation at both screen edges
  always_comb begin
    xpos_s  = xpos_r;
    dir_s   = dir_r;
    x_ext_s = {1'b0, xpos_r};
    if (move_s && bus.key_left && !bus.key_right) begin
      if (x_ext_s < WALK_11) begin
        xpos_s = 10'd0;
      end else begin
        xpos_s = 10'(x_ext_s - WALK_11);
      end
      dir_s = 1'b1;
    end else if (move_s && bus.key_right && !bus.key_left) begin
      if ((x_ext_s + WALK_11) > XMAX_11) begin
        xpos_s = 10'(XMAX_11);
      end else begin
        xpos_s = 10'(x_ext_s + WALK_11);
      end
      dir_s = 1'b0;
    end else begin
      xpos_s = xpos_r;
      dir_s  = dir_r;
    end
  end

  // Vertical FSM: jump launch, rise with head-bump clamp, gravity-limited fall
  always_comb begin
    state_s    = state_r;
    vy_s       = vy_r;
    ypos_s     = ypos_r;
    y_ext_s    = {2'b00, ypos_r};
    height_s   = player_height(size_r);
    rise_sum_s = y_ext_s + {6'b000000, vy_r};
    fall_vy_s  = {6'b000000, vy_r} + {6'b000000, GRAVITY_5};
    if (fall_vy_s > VMAX_11) begin
      fall_vy_s = VMAX_11;
    end else begin
      fall_vy_s = fall_vy_s;
    end
    case (state_r)
      GROUND: begin
        if (move_s && bus.key_jump) begin
          state_s = RISING;
          vy_s    = JUMP_V0_5;
        end else begin
          state_s = GROUND;
        end
      end
      RISING: begin
        if (move_s && ((rise_sum_s + height_s) > YMAX_11)) begin
          ypos_s  = 9'(YMAX_11 - height_s);
          state_s = FALLING;
          vy_s    = 5'd0;
        end else if (move_s) begin
          ypos_s = 9'(rise_sum_s);
          if (vy_r <= GRAVITY_5) begin
            state_s = FALLING;
            vy_s    = 5'd0;
          end else begin
            vy_s = vy_r - GRAVITY_5;
          end
        end else begin
          state_s = RISING;
        end
      end
      FALLING: begin
        if (move_s && (y_ext_s <= fall_vy_s)) begin
          ypos_s  = 9'd0;
          state_s = GROUND;
          vy_s    = 5'd0;
        end else if (move_s) begin
          ypos_s = 9'(y_ext_s - fall_vy_s);
          vy_s   = 5'(fall_vy_s);
        end else begin
          state_s = FALLING;
        end
      end
      default: begin
        state_s = GROUND;
        vy_s    = 5'd0;
        ypos_s  = 9'd0;
      end
    endcase
  end

  // Power-up ladder, evaluated every clock; hit outranks grow/flower
  always_comb begin
    size_s = size_r;
    fire_s = fire_r;
    dead_s = dead_r;
`ifdef PLAYER_FIRE_EN
    if (!dead_r && bus.hit) begin
      if (fire_r) begin
        fire_s = 1'b0;
        size_s = 1'b1;
      end else if (size_r) begin
        size_s = 1'b0;
      end else begin
        dead_s = 1'b1;
      end
    end else if (!dead_r && bus.flower) begin
      size_s = 1'b1;
      fire_s = 1'b1;
    end else if (!dead_r && bus.grow) begin
      size_s = 1'b1;
    end else begin
      size_s = size_r;
    end
`else
    fire_s = 1'b0;
    if (!dead_r && bus.hit) begin
      if (size_r) begin
        size_s = 1'b0;
      end else begin
        dead_s = 1'b1;
      end
    end else if (!dead_r && bus.grow) begin
      size_s = 1'b1;
    end else begin
      size_s = size_r;
    end
`endif
  end

  // State registers; reset returns the player to the start position at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos_r  <= 10'(XSTART);
      ypos_r  <= 9'd0;
      dir_r   <= 1'b0;
      size_r  <= 1'b0;
      fire_r  <= 1'b0;
      dead_r  <= 1'b0;
      state_r <= GROUND;
      vy_r    <= 5'd0;
    end else begin
      xpos_r  <= xpos_s;
      ypos_r  <= ypos_s;
      dir_r   <= dir_s;
      size_r  <= size_s;
      fire_r  <= fire_s;
      dead_r  <= dead_s;
      state_r <= state_s;
      vy_r    <= vy_s;
    end
  end

  assign bus.xpos      = xpos_r;
  assign bus.ypos      = ypos_r;
  assign bus.direction = dir_r;
  assign bus.size      = size_r;
  assign bus.fire      = fire_r;
  assign bus.dead      = dead_r;

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Produces the player state consumed by the sprite renderer: xpos, ypos, direction, size and fire.
- Walking and jump/gravity physics update once per video frame, on the rising edge of vsync_in.
- Power-up state (grow, hit, death) updates on any clock.
- Sits between the keyboard decoder and the player sprite stage in the video pipeline.

Parameters:
XSTART, 20, xpos after reset (pixels from left edge)
XMAX, 600, max xpos (640 - 40 player width)
YMAX, 400, max ypos + current player height (ceiling)
WALK_SPEED, 2, horizontal pixels per frame
JUMP_V0, 12, initial upward velocity (pixels/frame)
GRAVITY, 1, velocity change per frame
VFALL_MAX, 10, terminal falling velocity

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous active-high reset
vsync_in  input  1  vertical sync from timing chain; rising edge = frame tick
key_left  input  1  level, move left
key_right  input  1  level, move right
key_jump  input  1  level, jump request
grow  input  1  1-cycle pulse, mushroom collected
hit  input  1  1-cycle pulse, enemy contact
flower  input  1  1-cycle pulse, fire flower collected
xpos  output  10  left edge of player, pixels
ypos  output  9  bottom of player, pixels above screen bottom (0 = floor)
direction  output  1  1 = facing left (sprite mirrored), 0 = facing right
size  output  1  1 = big (80 px tall), 0 = small (40 px tall)
fire  output  1  fire-powered
dead  output  1  player dead; all movement frozen

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: xpos=XSTART, ypos=0, direction=0, size=0, fire=0, dead=0, FSM=GROUND, vy=0, vsync_d=0.
- Frame tick: tick = vsync_in & ~vsync_d, with vsync_d registered. Outputs change on the clock edge where tick=1, one cycle after vsync_in first samples high. No other movement updates occur.
- Horizontal motion, on tick with dead=0:
  - key_left only: xpos = max(xpos - WALK_SPEED, 0), direction=1.
  - key_right only: xpos = min(xpos + WALK_SPEED, XMAX), direction=0.
  - Both or neither pressed: xpos and direction hold.
- Arithmetic: saturate in 11-bit intermediates. No wrap-around.
- Vertical FSM, states GROUND/RISING/FALLING. vy is an unsigned 5-bit magnitude.
  - GROUND: on tick with key_jump=1, go to RISING with vy=JUMP_V0. ypos is unchanged on this tick.
  - RISING: on tick, ypos += vy, then vy -= GRAVITY.
    - If vy - GRAVITY <= 0, go to FALLING with vy=0.
    - If ypos + vy + height > YMAX, clamp ypos = YMAX - height and go to FALLING with vy=0 (head bump).
  - FALLING: on tick, vy = min(vy + GRAVITY, VFALL_MAX), then ypos -= new vy.
    - If the result is <= 0, ypos=0 and go to GROUND.
  - Holding key_jump in GROUND re-jumps on the next tick after landing. No edge detect is required.
- height = size ? 80 : 40, using the size value current at the tick.
- Power-up state, evaluated every clock:
  - hit=1: if fire, then fire=0 and size=1; else if size, then size=0; else dead=1.
  - Else grow=1: size=1.
  - hit has priority over grow/flower in the same cycle.
  - grow when already big has no effect.
- Pulses arriving on the same clock as a tick are applied in that cycle. The physics for that tick uses the pre-update size.
- Death: dead=1 is sticky until rst. With dead=1, all inputs are ignored and xpos, ypos, FSM and vy freeze.
- Reset mid-jump: immediate return to reset values. Asynchronous; no partial update.

Optional Feature:
- Macro: PLAYER_FIRE_EN.
- Defined: flower=1 sets size=1 and fire=1, with hit priority as above.
- Undefined: fire is held 0, the flower input is ignored, and the hit path skips the fire branch. The port list is unchanged.

Decomposition:
- Shared package (player_pkg):
  - Constants: PLAYER_WIDTH=40, SMALL=40, BIG=80, YRES=480, XRES=640.
  - State encoding typedef: GROUND=2'b00, RISING=2'b01, FALLING=2'b10.
  - Also used by the sprite stage.
- One sub-module is natural: frame_tick, the vsync rising-edge detector with registered vsync_d. It is reusable by enemy controllers.
- Physics and power-up logic stay in player_ctrl.

Test Plan:
1. Reset, then hold key_right for 5 vsync pulses: xpos=30, direction=0. Then key_left only for 20 pulses: xpos saturates at 0, direction=1.
2. From xpos=598, key_right for 1 pulse: xpos=600. Further pulses hold 600. Both keys held: xpos and direction unchanged.
3. key_jump for 1 frame, size=0, defaults: ypos after successive ticks 0,12,23,33,42,50,57,63,68,72,75,77,78. Then FALLING descent 77,75,72,…, landing with ypos=0 and FSM=GROUND. ypos never goes negative.
4. hit with size=0: dead=1; further key, vsync and grow activity leaves all outputs frozen. Sequence grow→hit gives size 1→0, dead=0. grow and hit in the same cycle on a small player gives dead=1.
5. With PLAYER_FIRE_EN: flower, then hit, then hit gives (size,fire) = (1,1)→(1,0)→(0,0). Without the macro, flower leaves fire=0.
6. Assert rst at ypos=42 during RISING: outputs immediately return to XSTART/0/0/0/0/0. The next jump starts cleanly from GROUND.
